// File: rtl/booth2_mul_pkg.sv
// rtl/booth2_mul_pkg.sv - shared types and Booth digit encoder for the sequential radix-4 multiplier
package booth2_mul_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        COMP,
        ADD,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_t;

    // Radix-4 Booth recoding of the triplet {b[2k+1], b[2k], b[2k-1]}.
    function automatic booth_t booth_encode(input logic [2:0] bits);
        booth_t code;
        case (bits)
            3'b001, 3'b010: code = POS1;
            3'b011:         code = POS2;
            3'b100:         code = NEG2;
            3'b101, 3'b110: code = NEG1;
            default:        code = ZERO;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/booth2_mul_cmp42.sv
// rtl/booth2_mul_cmp42.sv - single-bit 4-to-2 compressor cell
// Ports:
//   x0..x3  in   four equal-weight input bits
//   cin     in   lateral carry from the column one bit lower
//   sum     out  weight-1 result bit
//   carry   out  weight-2 result bit
//   cout    out  weight-2 lateral carry to the next column (independent of cin)
module booth2_mul_cmp42 (
    input  logic x0,
    input  logic x1,
    input  logic x2,
    input  logic x3,
    input  logic cin,
    output logic sum,
    output logic carry,
    output logic cout
);

    logic t;

    // First full adder folds x0..x2; its carry leaves sideways so cin never
    // depends on cout and the row has no ripple path.
    assign t     = x0 ^ x1 ^ x2;
    assign cout  = (x0 & x1) | (x0 & x2) | (x1 & x2);
    assign sum   = t ^ x3 ^ cin;
    assign carry = (t & x3) | (t & cin) | (x3 & cin);

endmodule

// File: rtl/booth2_mul_csa_row.sv
// rtl/booth2_mul_csa_row.sv - one row of 4-to-2 compressors folding two partial products into sum/carry
// Ports:
//   s, c        in   current carry-save accumulator
//   pp0, pp1    in   two partial products for this iteration
//   new_s       out  next accumulator sum word
//   new_c       out  next accumulator carry word (bit 0 always zero)
module booth2_mul_csa_row #(
    parameter int W = 64
) (
    input  logic [W-1:0] s,
    input  logic [W-1:0] c,
    input  logic [W-1:0] pp0,
    input  logic [W-1:0] pp1,
    output logic [W-1:0] new_s,
    output logic [W-1:0] new_c
);

    logic [W:0]   chain;
    logic [W-1:0] carry;
    logic         cout_msb_unused;
    logic         carry_msb_unused;

    assign chain[0] = 1'b0;

    for (genvar j = 0; j < W; j++) begin : g_col
        booth2_mul_cmp42 u_cell (
            .x0    (s[j]),
            .x1    (c[j]),
            .x2    (pp0[j]),
            .x3    (pp1[j]),
            .cin   (chain[j]),
            .sum   (new_s[j]),
            .carry (carry[j]),
            .cout  (chain[j+1])
        );
    end

    // Carry bits shift up one column; anything leaving the MSB is dropped
    // (arithmetic is modulo 2^W).
    assign new_c            = {carry[W-2:0], 1'b0};
    assign cout_msb_unused  = chain[W];
    assign carry_msb_unused = carry[W-1];

endmodule

// File: rtl/booth2_mul_seq_ctrl.sv
// rtl/booth2_mul_seq_ctrl.sv - sequencer for a multi-cycle signed radix-4 Booth multiplier
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   in_vld/in_rdy      operand handshake; in_a multiplicand, in_b multiplier (signed)
//   out_vld/out_rdy    result handshake; out_p = in_a*in_b (signed, 2*DATA_W bits)
//   busy               high whenever a job is in flight
module booth2_mul_seq_ctrl
    import booth2_mul_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [DATA_W-1:0]     in_a,
    input  logic [DATA_W-1:0]     in_b,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [2*DATA_W-1:0]   out_p,
    output logic                  busy
);

    localparam int P_W    = 2 * DATA_W;
    localparam int ITER_N = DATA_W / 4;
    localparam int CNT_W  = $clog2(ITER_N);
    localparam int IDX_W  = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER_N - 1);

    state_t            state, next_state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] a_q, b_q;
    logic [P_W-1:0]    acc_s, acc_c;

    logic [DATA_W:0]   b_ext;
    logic [IDX_W-1:0]  idx0, idx1;
    booth_t            code0, code1;
    logic [P_W-1:0]    pp0, pp1;
    logic [P_W-1:0]    new_s, new_c;

    // Sign-extended multiple of a, negated in full product width so -2a of
    // the most negative operand cannot overflow, then weighted by 4^k.
    function automatic logic [P_W-1:0] gen_pp(input booth_t code,
                                              input logic [DATA_W-1:0] a,
                                              input logic [IDX_W-1:0] sh);
        logic [P_W-1:0] a_ext;
        logic [P_W-1:0] mag;
        a_ext = {{DATA_W{a[DATA_W-1]}}, a};
        case (code)
            POS1:    mag = a_ext;
            POS2:    mag = a_ext << 1;
            NEG1:    mag = -a_ext;
            NEG2:    mag = -(a_ext << 1);
            default: mag = '0;
        endcase
        return mag << sh;
    endfunction

    // b[-1] = 0 is the appended LSB; digit k then sits at b_ext[2k +: 3].
    // Iteration cnt handles digits 2*cnt and 2*cnt+1, i.e. bit offsets 4*cnt and 4*cnt+2.
    assign b_ext = {b_q, 1'b0};
    assign idx0  = IDX_W'({cnt, 2'b00});
    assign idx1  = idx0 + IDX_W'(2);
    assign code0 = booth_encode(b_ext[idx0 +: 3]);
    assign code1 = booth_encode(b_ext[idx1 +: 3]);
    assign pp0   = gen_pp(code0, a_q, idx0);
    assign pp1   = gen_pp(code1, a_q, idx1);

    booth2_mul_csa_row #(
        .W (P_W)
    ) u_csa_row (
        .s     (acc_s),
        .c     (acc_c),
        .pp0   (pp0),
        .pp1   (pp1),
        .new_s (new_s),
        .new_c (new_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_vld)      next_state = COMP;
            COMP:    if (cnt == LAST) next_state = ADD;
            ADD:                      next_state = DONE;
            DONE:    if (out_rdy)     next_state = IDLE;
            default:                  next_state = IDLE;
        endcase
    end

    assign in_rdy  = (state == IDLE);
    assign out_vld = (state == DONE);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc_s <= '0;
            acc_c <= '0;
            out_p <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_vld) begin
                        a_q   <= in_a;
                        b_q   <= in_b;
                        acc_s <= '0;
                        acc_c <= '0;
                        cnt   <= '0;
                    end
                end
                COMP: begin
                    acc_s <= new_s;
                    acc_c <= new_c;
                    if (cnt != LAST) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ADD: begin
                    out_p <= acc_s + acc_c;
                end
                default: ;
            endcase
        end
    end

endmodule
